// File: rtl/pio_imem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
//   Shared constants for the PIO instruction-memory slice: default SM count,
//   instruction address/data widths, the 3-bit major opcodes used to build
//   instruction words, and the modulo helper used by the round-robin picker.
// -----------------------------------------------------------------------------
package pio_pkg;

  localparam int NUM_SM      = 4;
  localparam int IMEM_ADDR_W = 5;
  localparam int INSTR_W     = 16;

  // Major opcode lives in instr[15:13]; an all-zero word is "JMP 0, always".
  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_SET  = 3'b111;

  // Single-step wrap: callers only ever pass v in [0, 2*n).
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/pio_imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// pio_imem_arbiter_if
//   Host program-load port plus the per-SM fetch port of the shared PIO
//   instruction memory.
//   master : host / SM side  (drives write + fetch requests, sees grants/data)
//   slave  : arbiter side
//   Signals:
//     host_wr_en/addr/data, host_wr_ready  - host write, accepted on en & ready
//     sm_req, sm_addr                      - per-SM level request, packed addrs
//                                            (SM i at [i*ADDR_W +: ADDR_W])
//     sm_gnt                               - one-hot grant, same cycle as req
//     sm_rvalid, sm_rdata                  - registered fetch response
//     busy                                 - any request or response in flight
// -----------------------------------------------------------------------------
interface pio_imem_arbiter_if #(
  parameter int NUM_SM = pio_pkg::NUM_SM,
  parameter int ADDR_W = pio_pkg::IMEM_ADDR_W,
  parameter int DATA_W = pio_pkg::INSTR_W
);

  logic                     host_wr_en;
  logic [ADDR_W-1:0]        host_wr_addr;
  logic [DATA_W-1:0]        host_wr_data;
  logic                     host_wr_ready;
  logic [NUM_SM-1:0]        sm_req;
  logic [NUM_SM*ADDR_W-1:0] sm_addr;
  logic [NUM_SM-1:0]        sm_gnt;
  logic [NUM_SM-1:0]        sm_rvalid;
  logic [DATA_W-1:0]        sm_rdata;
  logic                     busy;

  modport master (
    output host_wr_en, host_wr_addr, host_wr_data, sm_req, sm_addr,
    input  host_wr_ready, sm_gnt, sm_rvalid, sm_rdata, busy
  );

  modport slave (
    input  host_wr_en, host_wr_addr, host_wr_data, sm_req, sm_addr,
    output host_wr_ready, sm_gnt, sm_rvalid, sm_rdata, busy
  );

endinterface

// File: rtl/pio_imem_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pio_rr_arbiter
//   Generic combinational round-robin picker.
//   req     in   NUM_REQ  request vector
//   ptr     in   PTR_W    index searched first; search wraps modulo NUM_REQ
//   gnt     out  NUM_REQ  one-hot grant (zero when no request)
//   ptr_nxt out  PTR_W    winner + 1 (mod NUM_REQ), or ptr when nothing granted
// -----------------------------------------------------------------------------
module pio_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   ptr_nxt
);

  import pio_pkg::rr_wrap;

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'(rr_wrap(int'(ptr) + i, NUM_REQ));
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = PTR_W'(rr_wrap(int'(idx) + 1, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/pio_imem_arbiter.sv
// -----------------------------------------------------------------------------
// pio_imem_arbiter
//   Shared 2**ADDR_W x DATA_W PIO instruction memory with a single read port
//   time-shared round-robin between NUM_SM state machines, plus a host write
//   port for program load. An accepted host write wins the cycle outright.
//   Ports:
//     clk  - clock, all state on posedge
//     rst  - asynchronous, active-high reset (clears memory to JMP 0)
//     bus  - pio_imem_arbiter_if.slave (host write + per-SM fetch signals)
//   Build option:
//     PIO_IMEM_STARVE_GUARD_EN - when defined, after 4 consecutive accepted
//       writes with a fetch pending, host_wr_ready drops for one cycle so the
//       SMs get a read slot. Undefined: host_wr_ready is tied high.
// -----------------------------------------------------------------------------
module pio_imem_arbiter #(
  parameter int NUM_SM = pio_pkg::NUM_SM,
  parameter int ADDR_W = pio_pkg::IMEM_ADDR_W,
  parameter int DATA_W = pio_pkg::INSTR_W
) (
  input logic              clk,
  input logic              rst,
  pio_imem_arbiter_if.slave bus
);

  import pio_pkg::OP_JMP;

  localparam int PTR_W = $clog2(NUM_SM);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_nxt;
  logic [NUM_SM-1:0] arb_req;
  logic [NUM_SM-1:0] gnt;
  logic [NUM_SM-1:0] rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_ready;
  logic              wr_accept;

  // ---------------------------------------------------------------------------
  // Host write acceptance
  // ---------------------------------------------------------------------------
`ifdef PIO_IMEM_STARVE_GUARD_EN
  localparam logic [2:0] STREAK_MAX = 3'd4;

  logic [2:0] streak;

  // Ready drops exactly on the cycle the streak hits 4; that cycle has no
  // accepted write, so the counter clears and the next write is accepted.
  assign wr_ready = (streak != STREAK_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (wr_accept && |bus.sm_req) begin
      streak <= streak + 3'd1;
    end else begin
      streak <= '0;
    end
  end
`else
  assign wr_ready = 1'b1;
`endif

  assign wr_accept = bus.host_wr_en & wr_ready;

  // ---------------------------------------------------------------------------
  // Read arbitration: a write cycle (or reset) offers no requests to the picker
  // ---------------------------------------------------------------------------
  assign arb_req = (rst || wr_accept) ? '0 : bus.sm_req;

  pio_rr_arbiter #(
    .NUM_REQ (NUM_SM),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .ptr_nxt (rr_ptr_nxt)
  );

  // Address of the granted SM (grant is one-hot, so OR-reduction is exact).
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      if (gnt[i]) begin
        rd_addr = rd_addr | bus.sm_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  // NOTE: the memory is reset word by word because SMs must fetch a defined
  // JMP 0 after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {OP_JMP, {(DATA_W-3){1'b0}}};
      end
    end else if (wr_accept) begin
      mem[bus.host_wr_addr] <= bus.host_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and registered fetch response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      rvalid <= gnt;
      if (|gnt) begin
        rdata <= mem[rd_addr];
      end
    end
  end

  assign bus.host_wr_ready = wr_ready;
  assign bus.sm_gnt        = gnt;
  assign bus.sm_rvalid     = rvalid;
  assign bus.sm_rdata      = rdata;
  assign bus.busy          = (|bus.sm_req) | (|rvalid);

endmodule

// File: tb/tb_pio_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pio_imem_arbiter
//   Directed bench for pio_imem_arbiter (default parameters: 4 SMs, 32 x 16b).
//   Inputs change 1 ns after posedge; outputs are sampled on negedge. In the
//   vector table, exp_rvalid/exp_rdata describe the response visible in that
//   row's cycle, i.e. the result of the previous row's grant.
// -----------------------------------------------------------------------------
module tb_pio_imem_arbiter;
  import pio_pkg::*;

  localparam int N  = NUM_SM;
  localparam int AW = IMEM_ADDR_W;
  localparam int DW = INSTR_W;

  localparam logic [DW-1:0] W3  = {OP_SET,  13'h0025};  // 16'hE025
  localparam logic [DW-1:0] W7  = {OP_WAIT, 13'h0021};  // 16'h2021
  localparam logic [DW-1:0] W10 = 16'hA0C1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pio_imem_arbiter_if #(.NUM_SM(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  pio_imem_arbiter #(.NUM_SM(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_rvalid;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  function automatic logic [N*AW-1:0] pa(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                         input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [N-1:0] rq, input logic [N*AW-1:0] ad,
                              input logic [N-1:0] g, input logic [N-1:0] rv, input logic [DW-1:0] rd);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.req = rq; v.addr = ad;
    v.exp_gnt = g; v.exp_rvalid = rv; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [N-1:0] rq, input logic [N*AW-1:0] ad);
    @(posedge clk);
    #1;
    bus.host_wr_en   = we;
    bus.host_wr_addr = wa;
    bus.host_wr_data = wd;
    bus.sm_req       = rq;
    bus.sm_addr      = ad;
    @(negedge clk);
  endtask

  vec_t tbl [16];
  int   gcount [N];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1'b0, 5'd0,  16'h0, 4'b0000, pa(0, 0, 0, 0),   4'b0000, 4'b0001, 16'h0000);
    tbl[1]  = mk(1'b1, 5'd3,  W3,    4'b0000, pa(0, 0, 0, 0),   4'b0000, 4'b0000, 16'h0000);
    tbl[2]  = mk(1'b0, 5'd0,  16'h0, 4'b0010, pa(0, 3, 0, 0),   4'b0010, 4'b0000, 16'h0000);
    tbl[3]  = mk(1'b0, 5'd0,  16'h0, 4'b0000, pa(0, 0, 0, 0),   4'b0000, 4'b0010, W3);
    tbl[4]  = mk(1'b1, 5'd7,  W7,    4'b0001, pa(7, 0, 0, 0),   4'b0000, 4'b0000, W3);
    tbl[5]  = mk(1'b0, 5'd0,  16'h0, 4'b0001, pa(7, 0, 0, 0),   4'b0001, 4'b0000, W3);
    tbl[6]  = mk(1'b1, 5'd10, W10,   4'b0000, pa(0, 0, 0, 0),   4'b0000, 4'b0001, W7);
    tbl[7]  = mk(1'b0, 5'd0,  16'h0, 4'b0010, pa(0, 10, 0, 0), 4'b0010, 4'b0000, W7);
    tbl[8]  = mk(1'b0, 5'd0,  16'h0, 4'b0011, pa(3, 7, 0, 0),  4'b0001, 4'b0010, W10);
    tbl[9]  = mk(1'b0, 5'd0,  16'h0, 4'b0010, pa(3, 7, 0, 0),  4'b0010, 4'b0001, W3);
    tbl[10] = mk(1'b0, 5'd0,  16'h0, 4'b1111, pa(3, 7, 10, 0), 4'b0100, 4'b0010, W7);
    tbl[11] = mk(1'b0, 5'd0,  16'h0, 4'b1011, pa(3, 7, 10, 0), 4'b1000, 4'b0100, W10);
    tbl[12] = mk(1'b0, 5'd0,  16'h0, 4'b0011, pa(3, 7, 10, 0), 4'b0001, 4'b1000, 16'h0000);
    tbl[13] = mk(1'b0, 5'd0,  16'h0, 4'b0010, pa(3, 7, 10, 0), 4'b0010, 4'b0001, W3);
    tbl[14] = mk(1'b0, 5'd0,  16'h0, 4'b0000, pa(0, 0, 0, 0),  4'b0000, 4'b0010, W7);
    tbl[15] = mk(1'b0, 5'd0,  16'h0, 4'b0000, pa(0, 0, 0, 0),  4'b0000, 4'b0000, W7);

    // ---------------- reset state (requests asserted during reset) ----------
    rst              = 1'b1;
    bus.host_wr_en   = 1'b0;
    bus.host_wr_addr = '0;
    bus.host_wr_data = '0;
    bus.sm_req       = 4'b1111;
    bus.sm_addr      = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt",    32'(bus.sm_gnt),        32'h0);
    check("rst_rvalid", 32'(bus.sm_rvalid),     32'h0);
    check("rst_rdata",  32'(bus.sm_rdata),      32'h0);
    check("rst_busy",   32'(bus.busy),          32'h1);
    check("rst_ready",  32'(bus.host_wr_ready), 32'h1);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.sm_req = '0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // ---------------- SM0 back-to-back fetch of every address --------------
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, '0, '0, 4'b0001, pa(AW'(a), 0, 0, 0));
      check($sformatf("sweep_gnt[%0d]", a),    32'(bus.sm_gnt),    32'h1);
      check($sformatf("sweep_rvalid[%0d]", a), 32'(bus.sm_rvalid), (a == 0) ? 32'h0 : 32'h1);
      check($sformatf("sweep_rdata[%0d]", a),  32'(bus.sm_rdata),  32'h0);
    end

    // ---------------- vector table -----------------------------------------
    foreach (tbl[i]) begin
      drive(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data, tbl[i].req, tbl[i].addr);
      check($sformatf("vec%0d_gnt", i),    32'(bus.sm_gnt),        32'(tbl[i].exp_gnt));
      check($sformatf("vec%0d_rvalid", i), 32'(bus.sm_rvalid),     32'(tbl[i].exp_rvalid));
      check($sformatf("vec%0d_rdata", i),  32'(bus.sm_rdata),      32'(tbl[i].exp_rdata));
      check($sformatf("vec%0d_ready", i),  32'(bus.host_wr_ready), 32'h1);
      check($sformatf("vec%0d_busy", i),   32'(bus.busy),
            32'((|tbl[i].req) | (|tbl[i].exp_rvalid)));
    end

    // ---------------- reset pulse the cycle after a grant ------------------
    drive(1'b0, '0, '0, 4'b0100, pa(0, 0, 3, 0));
    check("pre_rst_gnt", 32'(bus.sm_gnt), 32'h4);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.sm_req  = 4'b1111;
    bus.sm_addr = pa(3, 3, 3, 3);
    @(negedge clk);
    check("mid_rst_rvalid", 32'(bus.sm_rvalid), 32'h0);
    check("mid_rst_rdata",  32'(bus.sm_rdata),  32'h0);
    check("mid_rst_gnt",    32'(bus.sm_gnt),    32'h0);

    // ---------------- fairness from rr_ptr=0, memory cleared ---------------
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("fair_gnt[%0d]", c),    32'(bus.sm_gnt),    32'(1 << (c % 4)));
      check($sformatf("fair_rvalid[%0d]", c), 32'(bus.sm_rvalid), (c == 0) ? 32'h0 : 32'(1 << ((c - 1) % 4)));
      check($sformatf("fair_rdata[%0d]", c),  32'(bus.sm_rdata),  32'h0);
      for (int i = 0; i < N; i++) gcount[i] += int'(bus.sm_gnt[i]);
    end
    for (int i = 0; i < N; i++) check($sformatf("fair_count[%0d]", i), 32'(gcount[i]), 32'd2);
    drive(1'b0, '0, '0, 4'b0000, '0);
    check("fair_last_rvalid", 32'(bus.sm_rvalid), 32'h8);

    // ---------------- sustained host writes with SM2 waiting ---------------
    for (int c = 0; c < 6; c++) begin
`ifdef PIO_IMEM_STARVE_GUARD_EN
      drive(1'b1, AW'(20 + c), DW'(16'h1000 + c), (c <= 4) ? 4'b0100 : 4'b0000, pa(0, 0, 5, 0));
      check($sformatf("wr_ready[%0d]", c), 32'(bus.host_wr_ready), (c == 4) ? 32'h0 : 32'h1);
      check($sformatf("wr_gnt[%0d]", c),   32'(bus.sm_gnt),        (c == 4) ? 32'h4 : 32'h0);
`else
      drive(1'b1, AW'(20 + c), DW'(16'h1000 + c), 4'b0100, pa(0, 0, 5, 0));
      check($sformatf("wr_ready[%0d]", c), 32'(bus.host_wr_ready), 32'h1);
      check($sformatf("wr_gnt[%0d]", c),   32'(bus.sm_gnt),        32'h0);
`endif
    end
`ifndef PIO_IMEM_STARVE_GUARD_EN
    drive(1'b0, '0, '0, 4'b0100, pa(0, 0, 5, 0));
    check("wr_release_gnt", 32'(bus.sm_gnt), 32'h4);
`endif

    // ---------------- read back writes from the burst ----------------------
    drive(1'b0, '0, '0, 4'b0010, pa(0, 24, 0, 0));
    check("rb24_gnt", 32'(bus.sm_gnt), 32'h2);
    drive(1'b0, '0, '0, 4'b0010, pa(0, 23, 0, 0));
    check("rb23_gnt", 32'(bus.sm_gnt), 32'h2);
`ifdef PIO_IMEM_STARVE_GUARD_EN
    check("rb24_rdata", 32'(bus.sm_rdata), 32'h0);
`else
    check("rb24_rdata", 32'(bus.sm_rdata), 32'h1004);
`endif
    drive(1'b0, '0, '0, 4'b0000, '0);
    check("rb23_rvalid", 32'(bus.sm_rvalid), 32'h2);
    check("rb23_rdata",  32'(bus.sm_rdata),  32'h1003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
